touch_brush_painter: RTL and testbench
======================================

// Module: touch_brush_painter
// PURPOSE
//  Turns accepted touch coordinates into VRAM pixel writes for the sketch display, one pixel per cycle.
//  Each touch paints a clipped square brush of configurable size and colour.
//  A full-screen clear mode fills the frame buffer with a single colour.
//  Sits between the touch controller front end and the VRAM write port; the display driver reads VRAM independently.
// PARAMETERS
//  DISPLAY_WIDTH   240  pixels per row
//  DISPLAY_HEIGHT  320  rows
//  COLOR_W         8    bits per pixel
//  BRUSH_SIZE      3    brush edge length in pixels; must be odd and >=1; radius R=(BRUSH_SIZE-1)/2
//  (local) X_W=$clog2(DISPLAY_WIDTH), Y_W=$clog2(DISPLAY_HEIGHT), ADDR_W=$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous, active-high reset
//  touch_valid   in   1        touch coordinate available
//  touch_ready   out  1        block can accept a touch this cycle
//  touch_x       in   X_W      touch column
//  touch_y       in   Y_W      touch row
//  touch_color   in   COLOR_W  brush colour for this touch
//  clear_req     in   1        request full-screen clear (level or pulse)
//  clear_color   in   COLOR_W  fill colour, sampled when the clear starts
//  vram_wr_ena   out  1        VRAM write strobe
//  vram_wr_addr  out  ADDR_W   VRAM address = y*DISPLAY_WIDTH + x
//  vram_wr_data  out  COLOR_W  pixel value
//  busy          out  1        high in PAINT or CLEAR
//  done          out  1        one-cycle pulse after the last write of a paint or clear
// BEHAVIOUR
//  - Reset: state IDLE, touch_ready=0 during the reset cycle then 1; vram_wr_ena/addr/data=0, busy=0, done=0, pending clear=0.
//  - States: IDLE, PAINT, CLEAR. All outputs registered.
//  - IDLE: touch_ready = !clear_req && !pending_clear. Clear has priority over touch in the same cycle.
//    - Clear seen -> CLEAR; latch clear_color; address counter = 0.
//    - Else touch_valid&&touch_ready -> latch x, y and colour; compute the clipped window -> PAINT.
//  - Clipped window:
//    - x0=max(0,x-R), x1=min(W-1,x+R); y0=max(0,y-R), y1=min(H-1,y+R).
//    - Compute in signed arithmetic wide enough that no wrap occurs.
//  - Out-of-range touch (x>=W or y>=H): accepted, zero writes; done pulses the cycle after acceptance; state returns to IDLE.
//  - PAINT: one write per cycle, raster order (x0..x1 inner loop, y0..y1 outer loop).
//    - First write is asserted the cycle after acceptance. Writes are contiguous with no bubbles.
//    - After the (x1,y1) write, next cycle: wr_ena=0, done=1. Then go to pending CLEAR if set, else IDLE.
//  - CLEAR: writes addresses 0..W*H-1, one per cycle, data = latched clear_color.
//    - done pulses the cycle after the final write; then go to IDLE. pending_clear is cleared on entering CLEAR.
//  - clear_req asserted during PAINT sets pending_clear. Touches are never queued; touch_ready=0 while busy.
//  - clear_req asserted during CLEAR is ignored (no restart).
//  - Reset mid-operation aborts immediately: wr_ena=0 on the next edge; no partial-state resume.
//  - Address arithmetic is unsigned at ADDR_W, y*DISPLAY_WIDTH computed in full width. It never exceeds W*H-1.
// TESTING
//  - Centre touch x=100,y=50,color=8'hA5, BRUSH 3: exactly 9 writes, addr 11859..11861, 12099..12101, 12339..12341, data A5; done 1 cycle after the last write.
//  - Corner touch x=0,y=0: 4 writes (addr 0,1,240,241). Corner x=239,y=319: 4 writes; the last has addr 76799.
//  - Out-of-range touch x=240,y=10: accepted, no vram_wr_ena, done pulses next cycle, touch_ready returns to 1.
//  - clear_req with clear_color=8'h00: 76800 contiguous writes addr 0..76799, busy high throughout, single done pulse.
//  - Both events in one cycle:
//    - clear_req and touch_valid in the same IDLE cycle -> clear runs, touch not accepted.
//    - clear_req pulsed during PAINT -> paint completes (9 writes), then a clear follows with 2 done pulses.
//  - Reset asserted mid-CLEAR at address 1000: wr_ena=0 next cycle; after release, IDLE with touch_ready=1 and no further writes.

Source files
------------

// File: rtl/touch_brush_painter.sv
// Brush painter: turns touches into clipped square VRAM writes, one pixel per cycle.
// Also provides a full-screen clear that fills the frame buffer with one colour.
module touch_brush_painter #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int COLOR_W        = 8,
  parameter int BRUSH_SIZE     = 3,
  localparam int X_W    = $clog2(DISPLAY_WIDTH),
  localparam int Y_W    = $clog2(DISPLAY_HEIGHT),
  localparam int ADDR_W = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               touch_valid,
  output logic               touch_ready,
  input  logic [X_W-1:0]     touch_x,
  input  logic [Y_W-1:0]     touch_y,
  input  logic [COLOR_W-1:0] touch_color,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               vram_wr_ena,
  output logic [ADDR_W-1:0]  vram_wr_addr,
  output logic [COLOR_W-1:0] vram_wr_data,
  output logic               busy,
  output logic               done
);

  localparam int R    = (BRUSH_SIZE - 1) / 2;
  localparam int NPIX = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAINT,
    S_CLEAR
  } state_t;

  state_t             r_state, w_state;
  logic               r_pend, w_pend;
  logic               r_rdy, w_rdy;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_wr_ena, w_wr_ena;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic [COLOR_W-1:0] r_data, w_data;
  logic [ADDR_W-1:0]  r_step, w_step;
  logic [X_W-1:0]     r_cx, w_cx;
  logic [Y_W-1:0]     r_cy, w_cy;
  logic [X_W-1:0]     r_x0, w_x0;
  logic [X_W-1:0]     r_x1, w_x1;
  logic [Y_W-1:0]     r_y1, w_y1;

  int   w_xi, w_yi;
  int   w_x0i, w_x1i, w_y0i, w_y1i;
  logic w_oor;

  // Clipped brush window in plain int arithmetic so x-R / x+R never wrap
  always_comb begin
    w_xi  = int'(touch_x);
    w_yi  = int'(touch_y);
    w_x0i = (w_xi - R < 0) ? 0 : w_xi - R;
    w_x1i = (w_xi + R > DISPLAY_WIDTH - 1) ? DISPLAY_WIDTH - 1 : w_xi + R;
    w_y0i = (w_yi - R < 0) ? 0 : w_yi - R;
    w_y1i = (w_yi + R > DISPLAY_HEIGHT - 1) ? DISPLAY_HEIGHT - 1 : w_yi + R;
    w_oor = (w_xi >= DISPLAY_WIDTH) || (w_yi >= DISPLAY_HEIGHT);
  end

  always_comb begin
    w_state  = r_state;
    w_pend   = r_pend;
    w_done   = 1'b0;
    w_wr_ena = 1'b0;
    w_addr   = r_addr;
    w_data   = r_data;
    w_step   = r_step;
    w_cx     = r_cx;
    w_cy     = r_cy;
    w_x0     = r_x0;
    w_x1     = r_x1;
    w_y1     = r_y1;
    unique case (r_state)
      S_IDLE: begin
        if (clear_req || r_pend) begin
          w_state  = S_CLEAR;
          w_pend   = 1'b0;
          w_wr_ena = 1'b1;
          w_addr   = '0;
          w_data   = clear_color;
        end else if (touch_valid && r_rdy) begin
          if (w_oor) begin
            w_done = 1'b1;
          end else begin
            w_state  = S_PAINT;
            w_wr_ena = 1'b1;
            w_addr   = ADDR_W'(w_y0i * DISPLAY_WIDTH + w_x0i);
            w_data   = touch_color;
            w_step   = ADDR_W'(DISPLAY_WIDTH - (w_x1i - w_x0i));
            w_cx     = X_W'(w_x0i);
            w_cy     = Y_W'(w_y0i);
            w_x0     = X_W'(w_x0i);
            w_x1     = X_W'(w_x1i);
            w_y1     = Y_W'(w_y1i);
          end
        end
      end
      S_PAINT: begin
        if (clear_req) w_pend = 1'b1;
        if (r_cx == r_x1 && r_cy == r_y1) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_wr_ena = 1'b1;
          if (r_cx == r_x1) begin
            w_cx   = r_x0;
            w_cy   = r_cy + Y_W'(1);
            w_addr = r_addr + r_step;
          end else begin
            w_cx   = r_cx + X_W'(1);
            w_addr = r_addr + ADDR_W'(1);
          end
        end
      end
      S_CLEAR: begin
        if (r_addr == LAST) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_wr_ena = 1'b1;
          w_addr   = r_addr + ADDR_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
    w_rdy  = (w_state == S_IDLE) && !w_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pend   <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_ena <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_step   <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
    end else begin
      r_state  <= w_state;
      r_pend   <= w_pend;
      r_rdy    <= w_rdy;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_wr_ena <= w_wr_ena;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_step   <= w_step;
      r_cx     <= w_cx;
      r_cy     <= w_cy;
      r_x0     <= w_x0;
      r_x1     <= w_x1;
      r_y1     <= w_y1;
    end
  end

  // A clear request arriving in IDLE wins over a touch in the same cycle
  assign touch_ready  = r_rdy & ~clear_req;
  assign vram_wr_ena  = r_wr_ena;
  assign vram_wr_addr = r_addr;
  assign vram_wr_data = r_data;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_touch_brush_painter.sv
// Bench for touch_brush_painter: random and directed touches against a
// window-enumeration model, plus clear, priority and mid-clear reset scenarios.
module tb_touch_brush_painter;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int R  = 1;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        touch_valid = 1'b0;
  logic        touch_ready;
  logic [7:0]  touch_x = '0;
  logic [8:0]  touch_y = '0;
  logic [7:0]  touch_color = '0;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_color = '0;
  logic        vram_wr_ena;
  logic [16:0] vram_wr_addr;
  logic [7:0]  vram_wr_data;
  logic        busy;
  logic        done;

  touch_brush_painter #(
    .DISPLAY_WIDTH(W),
    .DISPLAY_HEIGHT(H),
    .COLOR_W(8),
    .BRUSH_SIZE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .touch_valid(touch_valid),
    .touch_ready(touch_ready),
    .touch_x(touch_x),
    .touch_y(touch_y),
    .touch_color(touch_color),
    .clear_req(clear_req),
    .clear_color(clear_color),
    .vram_wr_ena(vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         q_addr[$];
  logic [7:0] q_data[$];
  int         q_cyc[$];
  int         e_addr[$];
  logic [7:0] e_data[$];
  int         n_done;
  int         first_done;
  int         rdy_busy;
  int         busy_low_wr;
  bit         timeout;

  // Expected writes: every in-bounds pixel of the square around (x,y), row by row
  task automatic model(input int x, input int y, input logic [7:0] c);
    e_addr.delete();
    e_data.delete();
    if (x < W && y < H) begin
      for (int yy = y - R; yy <= y + R; yy++)
        for (int xx = x - R; xx <= x + R; xx++)
          if (xx >= 0 && xx < W && yy >= 0 && yy < H) begin
            e_addr.push_back(yy * W + xx);
            e_data.push_back(c);
          end
    end
  endtask

  function automatic int first_diff(input int off);
    if (q_addr.size() < off + e_addr.size()) return -2;
    for (int i = 0; i < e_addr.size(); i++)
      if (q_addr[off+i] != e_addr[i] || q_data[off+i] !== e_data[i]) return i;
    return -1;
  endfunction

  task automatic send_touch(input int x, input int y, input logic [7:0] c);
    touch_x     = 8'(x);
    touch_y     = 9'(y);
    touch_color = c;
    touch_valid = 1'b1;
  endtask

  task automatic collect(input int ndone, input int clr_at, input int budget);
    int cyc;
    cyc = 0;
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    n_done = 0;
    first_done = -1;
    rdy_busy = 0;
    busy_low_wr = 0;
    timeout = 0;
    while (n_done < ndone && !timeout) begin
      if (cyc >= budget) begin
        timeout = 1;
      end else begin
        @(negedge clk);
        cyc++;
        touch_valid = 1'b0;
        clear_req   = (cyc == clr_at);
        if (vram_wr_ena === 1'b1) begin
          q_addr.push_back(int'(vram_wr_addr));
          q_data.push_back(vram_wr_data);
          q_cyc.push_back(cyc);
          if (busy !== 1'b1) busy_low_wr++;
        end
        if (busy === 1'b1 && touch_ready === 1'b1) rdy_busy++;
        if (done === 1'b1) begin
          n_done++;
          if (first_done < 0) first_done = cyc;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (touch_ready !== 1'b0 || vram_wr_ena !== 1'b0 || vram_wr_addr !== '0 ||
        vram_wr_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b ena=%b addr=%0d data=%h busy=%b done=%b, need all 0",
               touch_ready, vram_wr_ena, vram_wr_addr, vram_wr_data, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (touch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: touch_ready=%b need 1", touch_ready);
    end
  endtask

  task automatic test_center;
    int d;
    model(100, 50, 8'hA5);
    send_touch(100, 50, 8'hA5);
    collect(1, -1, 40);
    d = first_diff(0);
    n_tests++;
    if (timeout || q_addr.size() != 9 || d != -1) begin
      n_fail++;
      $display("FAIL center_writes: count=%0d diff_at=%0d timeout=%0d need 9 matching",
               q_addr.size(), d, timeout);
    end
    n_tests++;
    if (q_addr.size() != 9 || q_addr[0] != 11859 || q_addr[8] != 12341) begin
      n_fail++;
      $display("FAIL center_ends: got %0d writes, need first 11859 last 12341", q_addr.size());
    end
    n_tests++;
    if (q_cyc.size() != 9 || q_cyc[0] != 1 || q_cyc[8] != 9 || first_done != 10 || n_done != 1) begin
      n_fail++;
      $display("FAIL center_timing: writes=%0d done_cyc=%0d ndone=%0d need writes at 1..9 done at 10",
               q_cyc.size(), first_done, n_done);
    end
    n_tests++;
    if (rdy_busy != 0 || busy_low_wr != 0) begin
      n_fail++;
      $display("FAIL center_busy: rdy_while_busy=%0d writes_without_busy=%0d need 0/0",
               rdy_busy, busy_low_wr);
    end
  endtask

  task automatic test_corners;
    int d;
    @(negedge clk);
    model(0, 0, 8'h3C);
    send_touch(0, 0, 8'h3C);
    collect(1, -1, 40);
    d = first_diff(0);
    n_tests++;
    if (timeout || q_addr.size() != 4 || d != -1 || q_addr[3] != 241) begin
      n_fail++;
      $display("FAIL corner_00: count=%0d diff_at=%0d need 4 writes 0,1,240,241",
               q_addr.size(), d);
    end
    @(negedge clk);
    model(239, 319, 8'hC3);
    send_touch(239, 319, 8'hC3);
    collect(1, -1, 40);
    d = first_diff(0);
    n_tests++;
    if (timeout || q_addr.size() != 4 || d != -1 || q_addr[3] != 76799) begin
      n_fail++;
      $display("FAIL corner_239_319: count=%0d diff_at=%0d need 4 writes ending 76799",
               q_addr.size(), d);
    end
    n_tests++;
    if (q_cyc.size() != 4 || first_done != q_cyc[3] + 1) begin
      n_fail++;
      $display("FAIL corner_done: done_cyc=%0d need one after last write", first_done);
    end
  endtask

  task automatic test_out_of_range;
    int k;
    @(negedge clk);
    n_tests++;
    if (touch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready_before: touch_ready=%b need 1", touch_ready);
    end
    send_touch(240, 10, 8'h77);
    collect(1, -1, 10);
    n_tests++;
    if (timeout || q_addr.size() != 0 || first_done != 1) begin
      n_fail++;
      $display("FAIL oor_done: writes=%0d done_cyc=%0d need 0 writes, done at 1",
               q_addr.size(), first_done);
    end
    k = 0;
    while (touch_ready !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (touch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready_after: touch_ready=%b need 1", touch_ready);
    end
  endtask

  task automatic test_random;
    int x, y, d, k, n;
    logic [7:0] c;
    for (int t = 0; t < 24; t++) begin
      k = 0;
      while (touch_ready !== 1'b1 && k < 4) begin
        @(negedge clk);
        k++;
      end
      n_tests++;
      if (touch_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_ready t=%0d: touch_ready=%b need 1", t, touch_ready);
      end
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(0, 1); y = $urandom_range(0, H - 1); end
        1: begin x = $urandom_range(W - 2, W + 2); y = $urandom_range(H - 2, H + 2); end
        default: begin x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1); end
      endcase
      c = 8'($urandom);
      model(x, y, c);
      send_touch(x, y, c);
      collect(1, -1, 40);
      d = first_diff(0);
      n = e_addr.size();
      n_tests++;
      if (timeout || q_addr.size() != n || d != -1) begin
        n_fail++;
        $display("FAIL rand_writes x=%0d y=%0d: count=%0d diff_at=%0d need %0d",
                 x, y, q_addr.size(), d, n);
      end
      n_tests++;
      if (n == 0) begin
        if (first_done != 1) begin
          n_fail++;
          $display("FAIL rand_done x=%0d y=%0d: done_cyc=%0d need 1", x, y, first_done);
        end
      end else if (q_cyc.size() != n || q_cyc[0] != 1 || q_cyc[n-1] != n || first_done != n + 1) begin
        n_fail++;
        $display("FAIL rand_timing x=%0d y=%0d: done_cyc=%0d need contiguous 1..%0d then done",
                 x, y, first_done, n);
      end
    end
  endtask

  task automatic test_clear_during_paint;
    int bad;
    @(negedge clk);
    clear_color = 8'h00;
    model(120, 160, 8'h5F);
    send_touch(120, 160, 8'h5F);
    collect(2, 3, NP + 100);
    n_tests++;
    if (timeout || n_done != 2) begin
      n_fail++;
      $display("FAIL clr_paint_dones: dones=%0d timeout=%0d need 2", n_done, timeout);
    end
    n_tests++;
    if (first_diff(0) != -1) begin
      n_fail++;
      $display("FAIL clr_paint_brush: diff_at=%0d need 9 brush writes first", first_diff(0));
    end
    bad = 0;
    if (q_addr.size() != 9 + NP) begin
      bad = -1;
    end else begin
      for (int i = 0; i < NP; i++)
        if (q_addr[9+i] != i || q_data[9+i] !== 8'h00) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clr_fill: writes=%0d bad=%0d need %0d writes addr 0..%0d data 00",
               q_addr.size(), bad, 9 + NP, NP - 1);
    end
    n_tests++;
    if (q_cyc.size() != 9 + NP || q_cyc[9+NP-1] - q_cyc[9] + 1 != NP ||
        first_done != 10 || busy_low_wr != 0) begin
      n_fail++;
      $display("FAIL clr_contig: first_done=%0d writes_without_busy=%0d need contiguous, done at 10",
               first_done, busy_low_wr);
    end
  endtask

  task automatic test_priority_reset;
    int bad, wr;
    @(negedge clk);
    clear_color = 8'h5A;
    clear_req   = 1'b1;
    send_touch(10, 10, 8'hEE);
    #1;
    n_tests++;
    if (touch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ready: touch_ready=%b need 0 with clear_req", touch_ready);
    end
    bad = 0;
    for (int k = 0; k <= 1000; k++) begin
      @(negedge clk);
      touch_valid = 1'b0;
      clear_req   = 1'b0;
      if (vram_wr_ena !== 1'b1 || int'(vram_wr_addr) != k ||
          vram_wr_data !== 8'h5A || busy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL prio_clear: bad=%0d need clear writes 0..1000 data 5A", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b0 || touch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: ena=%b busy=%b rdy=%b need 0/0/0",
               vram_wr_ena, busy, touch_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (touch_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b busy=%b need 1/0", touch_ready, busy);
    end
    wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vram_wr_ena === 1'b1 || done === 1'b1) wr++;
    end
    n_tests++;
    if (wr != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: activity=%0d need 0 writes/done after reset", wr);
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_corners();
    test_out_of_range();
    test_random();
    test_clear_during_paint();
    test_priority_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
